uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_sync_2ff.sv | 21 ++
 rtl/uart_rx.sv | 121 ++++++++++++
 tb/tb_uart_rx.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry.
// Intended to be shared by uart_rx and the future uart_tx.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line and baud tick in, received data and status out.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);
    logic                 I_rx;
    logic                 I_baudrate_rx_clk;
    logic                 O_baudrate_rx_clk_en;
    logic [DATA_BITS-1:0] O_rx_data;
    logic                 O_rx_valid;
    logic                 O_rx_frame_err;
    logic                 O_rx_busy;

    modport slave (
        input  I_rx, I_baudrate_rx_clk,
        output O_baudrate_rx_clk_en, O_rx_data, O_rx_valid, O_rx_frame_err, O_rx_busy
    );

    modport master (
        output I_rx, I_baudrate_rx_clk,
        input  O_baudrate_rx_clk_en, O_rx_data, O_rx_valid, O_rx_frame_err, O_rx_busy
    );
endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; RST_VAL sets the idle level.
module uart_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualification at mid-start, LSB-first data,
// stop-bit check with frame-error and break hold.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave rx_if
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] MID_CNT  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic                 rx_s, rx_prev;
    logic                 tick, fall;
    logic [CW-1:0]        tick_cnt_q, tick_cnt_d, tick_inc;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;

    uart_sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_if.I_rx),
        .q   (rx_s)
    );

    assign tick     = rx_if.I_baudrate_rx_clk;
    assign tick_inc = tick_cnt_q + 1'b1;
    // Edge tracking runs in every state so a start bit landing on the IDLE return cycle is seen.
    assign fall     = rx_prev & ~rx_s;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        if (state_q != ST_IDLE && tick)
            tick_cnt_d = tick_inc;

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            ST_START: begin
                if (tick && tick_inc == MID_CNT) begin
                    tick_cnt_d = '0;
                    state_d    = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick && tick_inc == '0) begin
                    shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT)
                        state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick && tick_inc == '0) begin
                    if (rx_s) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rx_prev    <= 1'b1;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_prev    <= rx_s;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign rx_if.O_rx_data            = data_q;
    assign rx_if.O_rx_valid           = valid_q;
    assign rx_if.O_rx_frame_err       = err_q;
    assign rx_if.O_rx_busy            = (state_q != ST_IDLE);
    assign rx_if.O_baudrate_rx_clk_en = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8-bit and a 7-bit receiver share clock, reset and a
// tick every 4 clk (one bit = 16 ticks = 64 clk).
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic rx8 = 1'b1;
    logic rx7 = 1'b1;

    int vec_cnt = 0;
    int mis_cnt = 0;
    int err8 = 0;
    int err7 = 0;
    int both_cnt = 0;
    logic [7:0] q8[$];
    logic [6:0] q7[$];

    uart_rx_if #(.DATA_BITS(8)) bus8();
    uart_rx_if #(.DATA_BITS(7)) bus7();

    assign bus8.I_rx              = rx8;
    assign bus8.I_baudrate_rx_clk = tick;
    assign bus7.I_rx              = rx7;
    assign bus7.I_baudrate_rx_clk = tick;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut8 (.clk(clk), .rst(rst), .rx_if(bus8));
    uart_rx #(.DATA_BITS(7), .OVERSAMPLE(16)) dut7 (.clk(clk), .rst(rst), .rx_if(bus7));

    always #5 clk = ~clk;

    initial begin
        int c = 0;
        forever begin
            @(negedge clk);
            tick = (c == 0);
            c = (c + 1) % 4;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus8.O_rx_valid) q8.push_back(bus8.O_rx_data);
            if (bus8.O_rx_frame_err) err8++;
            if (bus7.O_rx_valid) q7.push_back(bus7.O_rx_data);
            if (bus7.O_rx_frame_err) err7++;
            if ((bus8.O_rx_valid && bus8.O_rx_frame_err) || (bus7.O_rx_valid && bus7.O_rx_frame_err))
                both_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_rx(input int port, input logic v);
        if (port == 8) rx8 = v;
        else rx7 = v;
    endtask

    // Start bit, nbits data LSB first, then the stop level which is left on the line.
    task automatic send_frame(input int port, input logic [7:0] d, input int nbits, input logic stop);
        set_rx(port, 1'b0);
        repeat (32) @(negedge clk);
        chk("busy_in_start", (port == 8) ? bus8.O_rx_busy : bus7.O_rx_busy, 1);
        repeat (32) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            set_rx(port, d[i]);
            repeat (64) @(negedge clk);
        end
        set_rx(port, stop);
        repeat (64) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data8", bus8.O_rx_data, 0);
        chk("rst_valid8", bus8.O_rx_valid, 0);
        chk("rst_err8", bus8.O_rx_frame_err, 0);
        chk("rst_busy8", bus8.O_rx_busy, 0);
        chk("rst_en8", bus8.O_baudrate_rx_clk_en, 0);
        chk("rst_data7", bus7.O_rx_data, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // good frame 0x55
        send_frame(8, 8'h55, 8, 1'b1);
        repeat (40) @(negedge clk);
        chk("f55_cnt", q8.size(), 1);
        chk("f55_data", (q8.size() > 0) ? 32'(q8[0]) : 32'hdead, 32'h55);
        chk("f55_err", err8, 0);
        chk("f55_busy", bus8.O_rx_busy, 0);
        chk("f55_en", bus8.O_baudrate_rx_clk_en, 0);

        // bad stop on 0xA5, line held low afterwards
        q8.delete();
        send_frame(8, 8'hA5, 8, 1'b0);
        repeat (200) @(negedge clk);
        chk("fa5_err", err8, 1);
        chk("fa5_valid", q8.size(), 0);
        chk("fa5_data_held", bus8.O_rx_data, 32'h55);
        chk("fa5_break_busy", bus8.O_rx_busy, 1);
        rx8 = 1'b1;
        repeat (10) @(negedge clk);
        chk("fa5_idle_busy", bus8.O_rx_busy, 0);

        // 5-tick low glitch
        err8 = 0;
        rx8 = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_busy_mid", bus8.O_rx_busy, 1);
        repeat (10) @(negedge clk);
        rx8 = 1'b1;
        repeat (100) @(negedge clk);
        chk("glitch_valid", q8.size(), 0);
        chk("glitch_err", err8, 0);
        chk("glitch_busy", bus8.O_rx_busy, 0);
        chk("glitch_en", bus8.O_baudrate_rx_clk_en, 0);

        // back-to-back 0x00, 0xFF
        send_frame(8, 8'h00, 8, 1'b1);
        send_frame(8, 8'hFF, 8, 1'b1);
        repeat (40) @(negedge clk);
        chk("b2b_cnt", q8.size(), 2);
        chk("b2b_first", (q8.size() > 0) ? 32'(q8[0]) : 32'hdead, 32'h00);
        chk("b2b_second", (q8.size() > 1) ? 32'(q8[1]) : 32'hdead, 32'hFF);
        chk("b2b_err", err8, 0);

        // reset during data bit 3 of 0x3C (bits LSB first: 0,0,1,1,...)
        q8.delete();
        rx8 = 1'b0; repeat (64) @(negedge clk);
        rx8 = 1'b0; repeat (64) @(negedge clk);
        rx8 = 1'b0; repeat (64) @(negedge clk);
        rx8 = 1'b1; repeat (64) @(negedge clk);
        rx8 = 1'b1; repeat (32) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_data", bus8.O_rx_data, 0);
        chk("mid_rst_busy", bus8.O_rx_busy, 0);
        chk("mid_rst_en", bus8.O_baudrate_rx_clk_en, 0);
        chk("mid_rst_valid", bus8.O_rx_valid, 0);
        chk("mid_rst_err", bus8.O_rx_frame_err, 0);
        rx8 = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("post_rst_valid", q8.size(), 0);
        chk("post_rst_err", err8, 0);
        send_frame(8, 8'hC3, 8, 1'b1);
        repeat (40) @(negedge clk);
        chk("fc3_cnt", q8.size(), 1);
        chk("fc3_data", (q8.size() > 0) ? 32'(q8[0]) : 32'hdead, 32'hC3);
        chk("fc3_err", err8, 0);

        // 7-bit receiver, frame 0x7F
        q8.delete();
        send_frame(7, 8'h7F, 7, 1'b1);
        repeat (40) @(negedge clk);
        chk("f7_cnt", q7.size(), 1);
        chk("f7_data", (q7.size() > 0) ? 32'(q7[0]) : 32'hdead, 32'h7F);
        chk("f7_err", err7, 0);
        chk("f7_busy", bus7.O_rx_busy, 0);
        chk("f7_port8_quiet", q8.size(), 0);
        chk("never_both", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end
endmodule
